// File: rtl/int_ctrl.sv
// int_ctrl: single-level interrupt controller for NSRC timer pulse sources.
//
// Rising edges on src_pulse latch into pending (whether masked or not). A
// second edge on a source whose event is still pending sets that source's
// sticky overrun flag. When enabled pending events exist, the lowest-index
// one is presented to the CPU on irq/vector. After ack the controller stays
// in service until eoi. Nested interrupts are not supported: events that
// arrive during service only latch as pending.
//
// Ports
//   clk         single clock, rising edge
//   reset       asynchronous, active-high reset
//   src_pulse   [NSRC] timer pulse inputs, edge detected
//   we, wdata   mask register write strobe and data (1 = source enabled)
//   ack         CPU accepts the request currently on irq/vector
//   eoi         CPU ends service of the current interrupt
//   irq         registered interrupt request, high only in REQ
//   vector      [VW] index of the requested or in-service source
//   mask        [NSRC] current mask register
//   pending     [NSRC] latched, unserviced events
//   ovf         [NSRC] sticky overrun flags
//   in_service  high while in SERVICE
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for an enabled pending source to arbitrate
// REQ     | irq high, vector frozen, waiting for the CPU to ack
// SERVICE | CPU servicing vector, waiting for eoi

module int_ctrl #(
    parameter int NSRC = 4,
    parameter int VW   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src_pulse,
    input  logic            we,
    input  logic [NSRC-1:0] wdata,
    input  logic            ack,
    input  logic            eoi,
    output logic            irq,
    output logic [VW-1:0]   vector,
    output logic [NSRC-1:0] mask,
    output logic [NSRC-1:0] pending,
    output logic [NSRC-1:0] ovf,
    output logic            in_service
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [NSRC-1:0] ONE_HOT0 = {{(NSRC-1){1'b0}}, 1'b1};

    state_t          state;
    state_t          state_nxt;
    logic [NSRC-1:0] prev;
    logic [NSRC-1:0] evt;
    logic [NSRC-1:0] req_vec;
    logic [NSRC-1:0] clr;
    logic [NSRC-1:0] pending_nxt;
    logic [NSRC-1:0] ovf_nxt;
    logic [VW-1:0]   arb_idx;
    logic [VW-1:0]   vector_nxt;
    logic            arb_hit;
    logic            take_ack;

    // A level held high produces exactly one event; prev resets to 0 so a
    // source already high at reset release counts once.
    assign evt     = src_pulse & ~prev;
    assign req_vec = pending & mask;
    assign arb_hit = |req_vec;

    // Lowest set index wins: scan downward so the last hit is the lowest.
    always_comb begin
        arb_idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                arb_idx = VW'(i);
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        vector_nxt = vector;
        take_ack   = 1'b0;
        case (state)
            IDLE: begin
                if (arb_hit) begin
                    vector_nxt = arb_idx;
                    state_nxt  = REQ;
                end
            end
            REQ: begin
                // A mask change here does not withdraw the request; only ack
                // leaves REQ.
                if (ack) begin
                    take_ack  = 1'b1;
                    state_nxt = SERVICE;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // On ack the serviced source's pending and overrun bits clear. A fresh
    // edge on that same source in the ack cycle re-sets pending (set wins),
    // while its overrun flag still clears.
    assign clr         = take_ack ? (ONE_HOT0 << vector) : '0;
    assign pending_nxt = (pending & ~clr) | evt;
    assign ovf_nxt     = (ovf | (evt & pending)) & ~clr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            irq    <= 1'b0;
            vector <= '0;
        end else begin
            state  <= state_nxt;
            // irq comes straight from a flop so it cannot glitch, and it
            // tracks the REQ state exactly.
            irq    <= (state_nxt == REQ);
            vector <= vector_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev    <= '0;
            pending <= '0;
            ovf     <= '0;
            mask    <= '0;
        end else begin
            prev    <= src_pulse;
            pending <= pending_nxt;
            ovf     <= ovf_nxt;
            if (we) begin
                mask <= wdata;
            end
        end
    end

    assign in_service = (state == SERVICE);

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: scoreboard bench for int_ctrl (NSRC=4, VW=2).
//
// Each stimulus cycle advances a behavioural reference model and pushes the
// expected post-edge output snapshot into a queue; an independent monitor
// pops and compares after every rising edge. Directed scenarios cover the
// basic flow, priority, masking, level/overrun, ack collision and
// asynchronous reset; a randomized phase follows.

module tb_int_ctrl;

    typedef struct packed {
        logic       irq;
        logic [1:0] vector;
        logic [3:0] mask;
        logic [3:0] pending;
        logic [3:0] ovf;
        logic       in_service;
    } snap_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] src_pulse = '0;
    logic       we = 1'b0;
    logic [3:0] wdata = '0;
    logic       ack = 1'b0;
    logic       eoi = 1'b0;
    logic       irq;
    logic [1:0] vector;
    logic [3:0] mask;
    logic [3:0] pending;
    logic [3:0] ovf;
    logic       in_service;

    int vectors = 0;
    int miscompares = 0;

    snap_t sb_q[$];

    // Reference model: mode 0 = waiting, 1 = requesting, 2 = being serviced.
    int   m_mode;
    int   m_vec;
    bit [3:0] m_mask, m_pend, m_ovf, m_prev;

    int_ctrl #(.NSRC(4), .VW(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .src_pulse  (src_pulse),
        .we         (we),
        .wdata      (wdata),
        .ack        (ack),
        .eoi        (eoi),
        .irq        (irq),
        .vector     (vector),
        .mask       (mask),
        .pending    (pending),
        .ovf        (ovf),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    function automatic snap_t model_snap();
        snap_t s;
        s.irq        = (m_mode == 1);
        s.vector     = 2'(m_vec);
        s.mask       = m_mask;
        s.pending    = m_pend;
        s.ovf        = m_ovf;
        s.in_service = (m_mode == 2);
        return s;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_vec  = 0;
        m_mask = '0;
        m_pend = '0;
        m_ovf  = '0;
        m_prev = '0;
    endtask

    // One clock edge of the specified behaviour, using pre-edge values.
    task automatic model_tick(input bit [3:0] s, input bit w, input bit [3:0] wd,
                              input bit a, input bit e);
        bit [3:0] events;
        bit [3:0] cleared;
        bit [3:0] ready;
        events  = s & ~m_prev;
        cleared = '0;
        ready   = m_pend & m_mask;
        if (m_mode == 0 && ready != 0) begin
            for (int i = 0; i < 4; i++) begin
                if (ready[i]) begin
                    m_vec = i;
                    break;
                end
            end
            m_mode = 1;
        end else if (m_mode == 1 && a) begin
            cleared = 4'(1 << m_vec);
            m_mode  = 2;
        end else if (m_mode == 2 && e) begin
            m_mode = 0;
        end
        m_ovf  = (m_ovf | (events & m_pend)) & ~cleared;
        m_pend = (m_pend & ~cleared) | events;
        if (w) m_mask = wd;
        m_prev = s;
    endtask

    task automatic drive_push(input logic [3:0] s, input logic w, input logic [3:0] wd,
                              input logic a, input logic e);
        src_pulse = s;
        we        = w;
        wdata     = wd;
        ack       = a;
        eoi       = e;
        model_tick(s, w, wd, a, e);
        sb_q.push_back(model_snap());
    endtask

    task automatic step(input logic [3:0] s, input logic w, input logic [3:0] wd,
                        input logic a, input logic e);
        @(negedge clk);
        drive_push(s, w, wd, a, e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    endtask

    task automatic write_mask(input logic [3:0] m);
        step(4'b0000, 1'b1, m, 1'b0, 1'b0);
    endtask

    // Asynchronous reset between edges; outputs must clear immediately.
    task automatic do_reset(input logic [3:0] hold_src);
        snap_t act;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        act = {irq, vector, mask, pending, ovf, in_service};
        vectors++;
        if (act != '0) begin
            miscompares++;
            $display("FAIL async_reset: got irq=%0b vec=%0d mask=%b pend=%b ovf=%b insvc=%0b, want all zero",
                     act.irq, act.vector, act.mask, act.pending, act.ovf, act.in_service);
        end
        model_reset();
        src_pulse = hold_src;
        we = 1'b0; ack = 1'b0; eoi = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive_push(hold_src, 1'b0, 4'b0000, 1'b0, 1'b0);
    endtask

    // Monitor: compare the DUT against the oldest expected snapshot after each edge.
    always @(posedge clk) begin
        snap_t act;
        snap_t exp;
        #1;
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            act = {irq, vector, mask, pending, ovf, in_service};
            vectors++;
            if (act !== exp) begin
                miscompares++;
                $display("FAIL cycle_outputs @%0t: got irq=%0b vec=%0d mask=%b pend=%b ovf=%b insvc=%0b, want irq=%0b vec=%0d mask=%b pend=%b ovf=%b insvc=%0b",
                         $time, act.irq, act.vector, act.mask, act.pending, act.ovf, act.in_service,
                         exp.irq, exp.vector, exp.mask, exp.pending, exp.ovf, exp.in_service);
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive_push(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

        // Basic flow on source 0.
        write_mask(4'b0001);
        step(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
        idle(3);
        step(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
        idle(2);
        step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
        idle(2);

        // Priority: sources 3 and 1 together, 1 first then 3.
        write_mask(4'b1111);
        step(4'b1010, 1'b0, 4'b0000, 1'b0, 1'b0);
        idle(2);
        step(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
        idle(2);
        step(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
        idle(2);

        // Masked source 2, then enabled by a mask write.
        write_mask(4'b0000);
        step(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
        idle(4);
        write_mask(4'b0100);
        idle(3);
        step(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
        idle(2);

        // Level held high counts once; a second pulse sets overrun.
        write_mask(4'b0000);
        for (int k = 0; k < 10; k++) step(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
        idle(2);
        step(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
        idle(2);
        write_mask(4'b0001);
        idle(2);
        step(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
        idle(2);

        // Collision: ack and a fresh src0 edge in the same cycle.
        step(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
        idle(2);
        step(4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);
        idle(1);
        step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
        idle(2);
        step(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
        idle(2);

        // Asynchronous reset during SERVICE with pending=1010.
        step(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
        idle(2);
        step(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
        step(4'b1010, 1'b0, 4'b0000, 1'b0, 1'b0);
        idle(1);
        do_reset(4'b0100);
        idle(3);

        // Randomized phase; occasional resets, stray ack/eoi included.
        for (int n = 0; n < 1500; n++) begin
            logic [3:0] s;
            logic       w;
            logic       a;
            logic       e;
            s = 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
            w = ($urandom_range(0, 15) == 0);
            a = ($urandom_range(0, 2) == 0);
            e = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 299) == 0) begin
                do_reset(4'($urandom_range(0, 15)));
            end else begin
                step(s, w, 4'($urandom_range(0, 15)), a, e);
            end
        end

        @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter: NSRC, 4, number of timer pulse sources.
REQ-002 Parameter: VW, 2, vector width; NSRC SHALL be <= 2**VW.
REQ-003 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: src_pulse  input  NSRC  timer pulse outputs, one bit per source.
REQ-006 Port: we  input  1  mask register write enable.
REQ-007 Port: wdata  input  NSRC  new mask value (1 = source enabled).
REQ-008 Port: ack  input  1  CPU accepts the interrupt being requested.
REQ-009 Port: eoi  input  1  CPU signals end of interrupt service.
REQ-010 Port: irq  output  1  interrupt request to the CPU.
REQ-011 Port: vector  output  VW  index of the requested or in-service source.
REQ-012 Port: mask  output  NSRC  current mask register.
REQ-013 Port: pending  output  NSRC  latched, unserviced events.
REQ-014 Port: ovf  output  NSRC  sticky overrun flags.
REQ-015 Port: in_service  output  1  high while in state SERVICE.

Function
REQ-016 Edge detect: the block SHALL register src_pulse each cycle as prev; an event on source i SHALL be src_pulse[i] & ~prev[i], so a level held high counts once.
REQ-017 An event SHALL set pending[i] at the next clock edge, regardless of mask.
REQ-018 Overrun: an event on source i while pending[i] is already 1 SHALL set ovf[i].
REQ-019 Mask: when we=1, mask SHALL load wdata at the clock edge; the new value SHALL be used for arbitration from the following cycle.
REQ-020 FSM states SHALL be IDLE, REQ and SERVICE.
REQ-021 IDLE: if (pending & mask) != 0, the block SHALL latch vector = lowest set index, then enter REQ. irq SHALL be 1 from the next cycle, one cycle after the pending bit is visible.
REQ-022 REQ: irq=1 and vector SHALL remain stable until ack=1. A mask write during REQ SHALL NOT withdraw the request.
REQ-023 REQ with ack=1: the block SHALL clear pending[vector] and ovf[vector], drive irq=0, and enter SERVICE at the same edge.
REQ-024 Simultaneous new event on the acked source and ack: set SHALL win, so pending stays 1 and ovf is cleared.
REQ-025 SERVICE: in_service=1 and vector SHALL hold. eoi=1 SHALL return the FSM to IDLE. Nesting is not supported; new events SHALL only latch as pending.
REQ-026 ack outside REQ and eoi outside SERVICE SHALL be ignored.
REQ-027 Back-to-back: after eoi, the next IDLE cycle SHALL arbitrate the remaining pending sources per REQ-021.
REQ-028 irq SHALL be registered and glitch-free. irq=1 iff state=REQ.

Reset
REQ-029 While reset=1, regardless of clk: state=IDLE, irq=0, vector=0, mask=0, pending=0, ovf=0, prev=0, in_service=0.
REQ-030 Reset asserted mid-REQ or mid-SERVICE SHALL immediately abort to the values in REQ-029, with no ack or eoi needed.
REQ-031 After reset release, a src_pulse bit already high SHALL register as one event (prev=0).

Verification
REQ-032 Basic: mask=4'b0001, pulse src0 for 1 cycle -> pending=0001, then irq=1 with vector=0. Ack -> irq=0, pending=0000, in_service=1. Eoi -> IDLE.
REQ-033 Priority: mask=4'b1111, pulse src3 and src1 in the same cycle -> vector=1 first. After ack and eoi -> vector=3, irq=1.
REQ-034 Masked: mask=0000, pulse src2 -> pending=0100, irq stays 0. Write mask=0100 -> irq=1 with vector=2, two cycles after the write.
REQ-035 Level/overrun: hold src0 high for 10 cycles -> one event only. Two separate pulses on src0 before ack -> ovf=0001. Ack -> ovf=0000.
REQ-036 Collision: in REQ with vector=0, ack and a new src0 edge in the same cycle -> pending[0]=1 and in_service=1. After eoi, irq re-asserts with vector=0.
REQ-037 Reset: assert reset asynchronously during SERVICE with pending=1010 -> all outputs go to 0 without waiting for a clock edge.
